// File: rtl/updown_counter_param.sv
// Parameterised up/down counter with load, terminal-count pulse and zero/max flags.
// Define UDCNT_SATURATE_EN to hold at the boundaries instead of wrapping.
module updown_counter_param #(
  parameter int unsigned           WIDTH   = 8,
  parameter logic [WIDTH-1:0]      MAX_VAL = '1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             ud,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  output logic [WIDTH-1:0] count,
  output logic             tc,
  output logic             at_zero,
  output logic             at_max
);

  logic [WIDTH-1:0] count_d, count_q;
  logic             tc_d, tc_q;

  always_comb begin
    count_d = count_q;
    tc_d    = 1'b0;
    if (load) begin
      count_d = (load_val > MAX_VAL) ? MAX_VAL : load_val;
    end else if (en) begin
      if (ud) begin
        if (count_q >= MAX_VAL) begin
          tc_d = 1'b1;
`ifdef UDCNT_SATURATE_EN
          count_d = MAX_VAL;
`else
          count_d = '0;
`endif
        end else begin
          count_d = count_q + 1'b1;
        end
      end else begin
        if (count_q == '0) begin
          tc_d = 1'b1;
`ifdef UDCNT_SATURATE_EN
          count_d = '0;
`else
          count_d = MAX_VAL;
`endif
        end else begin
          count_d = count_q - 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      count_q <= '0;
      tc_q    <= 1'b0;
    end else begin
      count_q <= count_d;
      tc_q    <= tc_d;
    end
  end

  assign count   = count_q;
  assign tc      = tc_q;
  assign at_zero = (count_q == '0);
  assign at_max  = (count_q == MAX_VAL);

endmodule

// File: tb/tb_updown_counter_param.sv
// Directed bench for updown_counter_param: WIDTH=4/MAX_VAL=9 vector table plus a WIDTH=8 full-lap run.
module tb_updown_counter_param;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       en = 1'b0;
  logic       ud = 1'b0;
  logic       load = 1'b0;
  logic [3:0] load_val4 = '0;
  logic [7:0] load_val8 = '0;
  logic [3:0] count4;
  logic       tc4, at_zero4, at_max4;
  logic [7:0] count8;
  logic       tc8, at_zero8, at_max8;

  int unsigned total = 0;
  int unsigned bad = 0;

  always #5 clk = ~clk;

  updown_counter_param #(.WIDTH(4), .MAX_VAL(4'd9)) dut4 (
    .clk(clk), .rst(rst), .en(en), .ud(ud), .load(load), .load_val(load_val4),
    .count(count4), .tc(tc4), .at_zero(at_zero4), .at_max(at_max4)
  );

  updown_counter_param #(.WIDTH(8)) dut8 (
    .clk(clk), .rst(rst), .en(en), .ud(ud), .load(load), .load_val(load_val8),
    .count(count8), .tc(tc8), .at_zero(at_zero8), .at_max(at_max8)
  );

  typedef struct {
    logic       rst;
    logic       en;
    logic       ud;
    logic       load;
    logic [3:0] lv;
    logic [3:0] c;
    logic       tc;
  } vec_t;

  vec_t vec_q[$];

  task automatic add(input logic r, input logic e, input logic u, input logic l,
                     input logic [3:0] lv, input logic [3:0] c, input logic t);
    vec_t v;
    v.rst = r; v.en = e; v.ud = u; v.load = l; v.lv = lv; v.c = c; v.tc = t;
    vec_q.push_back(v);
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic drive(input logic r, input logic e, input logic u, input logic l,
                       input logic [3:0] lv);
    @(negedge clk);
    rst = r; en = e; ud = u; load = l; load_val4 = lv; load_val8 = {4'd0, lv};
    @(posedge clk);
    #1;
  endtask

  initial begin
    int unsigned tc_pulses;

    // reset, then 12 up steps
    add(1, 1, 1, 1, 4'd7, 4'd0, 0);
    for (int unsigned i = 1; i <= 9; i++) add(0, 1, 1, 0, 0, 4'(i), 0);
`ifdef UDCNT_SATURATE_EN
    add(0, 1, 1, 0, 0, 4'd9, 1);
    add(0, 1, 1, 0, 0, 4'd9, 1);
    add(0, 1, 1, 0, 0, 4'd9, 1);
    add(0, 1, 0, 0, 0, 4'd8, 0);
    add(0, 0, 0, 1, 4'd0, 4'd0, 0);
    add(0, 1, 0, 0, 0, 4'd0, 1);
    add(0, 1, 0, 0, 0, 4'd0, 1);
    add(0, 1, 0, 0, 0, 4'd0, 1);
    add(0, 0, 0, 0, 0, 4'd0, 0);
`else
    add(0, 1, 1, 0, 0, 4'd0, 1);
    add(0, 1, 1, 0, 0, 4'd1, 0);
    add(0, 1, 1, 0, 0, 4'd2, 0);
    add(0, 0, 0, 1, 4'd0, 4'd0, 0);
    add(0, 1, 0, 0, 0, 4'd9, 1);
    add(0, 1, 0, 0, 0, 4'd8, 0);
    add(0, 1, 0, 0, 0, 4'd7, 0);
    add(0, 0, 0, 0, 0, 4'd7, 0);
`endif
    // load clamp, then rst beating load
    add(0, 1, 1, 1, 4'd13, 4'd9, 0);
    add(1, 1, 1, 1, 4'd4, 4'd0, 0);
    // enable toggling, then direction flipping
    add(0, 0, 0, 1, 4'd3, 4'd3, 0);
    add(0, 1, 1, 0, 0, 4'd4, 0);
    add(0, 0, 1, 0, 0, 4'd4, 0);
    add(0, 1, 1, 0, 0, 4'd5, 0);
    add(0, 0, 1, 0, 0, 4'd5, 0);
    add(0, 1, 1, 0, 0, 4'd6, 0);
    add(0, 1, 0, 0, 0, 4'd5, 0);
    add(0, 1, 1, 0, 0, 4'd6, 0);
    add(0, 1, 0, 0, 0, 4'd5, 0);
    // reversal at max, consecutive boundary events
    add(0, 1, 0, 1, 4'd9, 4'd9, 0);
    add(0, 1, 0, 0, 0, 4'd8, 0);
    add(0, 0, 0, 1, 4'd9, 4'd9, 0);
`ifdef UDCNT_SATURATE_EN
    add(0, 1, 1, 0, 0, 4'd9, 1);
    add(0, 1, 1, 0, 0, 4'd9, 1);
    add(0, 1, 0, 0, 0, 4'd8, 0);
`else
    add(0, 1, 1, 0, 0, 4'd0, 1);
    add(0, 1, 0, 0, 0, 4'd9, 1);
    add(0, 1, 1, 0, 0, 4'd0, 1);
`endif
    add(0, 0, 1, 0, 0, vec_q[vec_q.size()-1].c, 0);
    // reset mid-count, restart from zero
    add(0, 0, 0, 1, 4'd6, 4'd6, 0);
    add(1, 1, 1, 0, 0, 4'd0, 0);
    add(0, 1, 1, 0, 0, 4'd1, 0);
    add(0, 1, 1, 0, 0, 4'd2, 0);

    for (int unsigned i = 0; i < vec_q.size(); i++) begin
      drive(vec_q[i].rst, vec_q[i].en, vec_q[i].ud, vec_q[i].load, vec_q[i].lv);
      chk($sformatf("v%0d.count", i), 32'(count4), 32'(vec_q[i].c));
      chk($sformatf("v%0d.tc", i), 32'(tc4), 32'(vec_q[i].tc));
      chk($sformatf("v%0d.at_zero", i), 32'(at_zero4), 32'(vec_q[i].c == 4'd0));
      chk($sformatf("v%0d.at_max", i), 32'(at_max4), 32'(vec_q[i].c == 4'd9));
    end

    // WIDTH=8 default MAX_VAL: a full 256-step lap from 0
    drive(1, 0, 0, 0, 0);
    chk("w8.rst_count", 32'(count8), 32'd0);
    chk("w8.rst_at_zero", 32'(at_zero8), 32'd1);
    chk("w8.rst_at_max", 32'(at_max8), 32'd0);
    tc_pulses = 0;
    for (int unsigned i = 1; i <= 256; i++) begin
      drive(0, 1, 1, 0, 0);
      if (tc8) tc_pulses++;
      if (i == 255) begin
        chk("w8.count_at_255", 32'(count8), 32'd255);
        chk("w8.at_max_at_255", 32'(at_max8), 32'd1);
      end
    end
`ifdef UDCNT_SATURATE_EN
    chk("w8.final_count", 32'(count8), 32'd255);
`else
    chk("w8.final_count", 32'(count8), 32'd0);
    chk("w8.final_at_zero", 32'(at_zero8), 32'd1);
`endif
    chk("w8.tc_pulses", 32'(tc_pulses), 32'd1);
    chk("w8.final_tc", 32'(tc8), 32'd1);
    drive(0, 0, 1, 0, 0);
    chk("w8.tc_clear", 32'(tc8), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
